// File: rtl/seq_bubble_sort_pkg.sv
// Shared definitions for the sequential odd-even transposition sorter:
// FSM state encoding and the counter-width helper.
package sort_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SORT   = 2'd1,
        UNLOAD = 2'd2
    } state_t;

    // Counters must be at least one bit wide even for tiny frames.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seq_bubble_sort_cmp_swap.sv
// Single compare-and-swap cell. Ascending by default; defining
// SORT_DESCENDING_EN flips the order. Equal operands never swap.
module cmp_swap #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    logic swap;

`ifdef SORT_DESCENDING_EN
    assign swap = en & (a < b);
`else
    assign swap = en & (a > b);
`endif

    assign lo_o = swap ? b : a;
    assign hi_o = swap ? a : b;

endmodule

// File: rtl/seq_bubble_sort.sv
// Streaming frame sorter: loads DIM elements, runs DIM odd-even transposition
// phases in place, then unloads. SORT_DESCENDING_EN selects descending order.
module seq_bubble_sort
    import sort_pkg::*;
#(
    parameter int DIM   = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int CW = cnt_width(DIM);
    localparam logic [CW-1:0] LAST_IDX = CW'(DIM - 1);

    state_t          state_reg;
    logic [CW-1:0]   in_cnt_reg;
    logic [CW-1:0]   phase_reg;
    logic [CW-1:0]   out_idx_reg;
    logic [WIDTH-1:0] mem [DIM];

    logic [WIDTH-1:0] even_res [DIM];
    logic [WIDTH-1:0] odd_res  [DIM];

    // Even phase: pairs (0,1),(2,3),...
    for (genvar gi = 0; gi < DIM / 2; gi++) begin : g_even
        cmp_swap #(.WIDTH(WIDTH)) u_cs (
            .a    (mem[2*gi]),
            .b    (mem[2*gi+1]),
            .en   (~phase_reg[0]),
            .lo_o (even_res[2*gi]),
            .hi_o (even_res[2*gi+1])
        );
    end
    if (DIM % 2 == 1) begin : g_even_tail
        assign even_res[DIM-1] = mem[DIM-1];
    end

    // Odd phase: pairs (1,2),(3,4),...; element 0 always passes through.
    assign odd_res[0] = mem[0];
    for (genvar gi = 0; gi < (DIM - 1) / 2; gi++) begin : g_odd
        cmp_swap #(.WIDTH(WIDTH)) u_cs (
            .a    (mem[2*gi+1]),
            .b    (mem[2*gi+2]),
            .en   (phase_reg[0]),
            .lo_o (odd_res[2*gi+1]),
            .hi_o (odd_res[2*gi+2])
        );
    end
    if (DIM % 2 == 0) begin : g_odd_tail
        assign odd_res[DIM-1] = mem[DIM-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= LOAD;
            in_cnt_reg  <= '0;
            phase_reg   <= '0;
            out_idx_reg <= '0;
            for (int i = 0; i < DIM; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state_reg)
                LOAD: begin
                    if (in_valid) begin
                        mem[in_cnt_reg] <= in_data;
                        if (in_cnt_reg == LAST_IDX) begin
                            in_cnt_reg <= '0;
                            phase_reg  <= '0;
                            state_reg  <= SORT;
                        end else begin
                            in_cnt_reg <= in_cnt_reg + 1'b1;
                        end
                    end
                end
                SORT: begin
                    for (int i = 0; i < DIM; i++) begin
                        mem[i] <= phase_reg[0] ? odd_res[i] : even_res[i];
                    end
                    if (phase_reg == LAST_IDX) begin
                        phase_reg   <= '0;
                        out_idx_reg <= '0;
                        state_reg   <= UNLOAD;
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        if (out_idx_reg == LAST_IDX) begin
                            out_idx_reg <= '0;
                            state_reg   <= LOAD;
                        end else begin
                            out_idx_reg <= out_idx_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= LOAD;
            endcase
        end
    end

    assign in_ready  = (state_reg == LOAD);
    assign out_valid = (state_reg == UNLOAD);
    assign busy      = ~in_ready;
    assign out_data  = mem[out_idx_reg];
    assign out_last  = out_valid & (out_idx_reg == LAST_IDX);

endmodule

// File: tb/tb_seq_bubble_sort.sv
// Bench for seq_bubble_sort: directed frame table, handshake corner cases,
// mid-sort reset and randomized frames against a reference sort.
module tb_seq_bubble_sort;

    localparam int DIM   = 4;
    localparam int WIDTH = 8;

    typedef logic [DIM-1:0][WIDTH-1:0] frame_t;
    typedef struct packed {
        frame_t din;
        frame_t exp;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    seq_bubble_sort #(.DIM(DIM), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: plain exchange sort in the configured direction.
    function automatic frame_t ref_sort(input frame_t d);
        frame_t a;
        logic [WIDTH-1:0] t;
        a = d;
        for (int p = 0; p < DIM; p++) begin
            for (int j = 0; j < DIM - 1; j++) begin
`ifdef SORT_DESCENDING_EN
                if (a[j] < a[j+1]) begin
`else
                if (a[j] > a[j+1]) begin
`endif
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
            end
        end
        return a;
    endfunction

    task automatic run_frame(input frame_t din, input frame_t exp,
                             input bit stall_test, input bit rand_bp);
        int n;
        int guard;
        bit r;
        frame_t got;
        logic [WIDTH-1:0] hold_data;
        logic hold_last;
        got = '0;
        for (int i = 0; i < DIM; i++) begin
            if (rand_bp) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            check("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_data  = din[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("busy_sort", busy, 1);
        check("in_ready_sort", in_ready, 0);
        // n counts edges starting with the accepting edge itself.
        n = 1;
        while (!out_valid && n < 64) begin
            if (stall_test) begin
                in_valid = 1'b1;
                in_data  = 8'hEE;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check("latency", n, DIM + 1);
        for (int k = 0; k < DIM; k++) begin
            check("out_valid", out_valid, 1);
            check("out_data", out_data, exp[k]);
            check("out_last", out_last, (k == DIM - 1) ? 1 : 0);
            got[k] = out_data;
            if (stall_test && k == 1) begin
                hold_data = out_data;
                hold_last = out_last;
                out_ready = 1'b0;
                repeat (3) begin
                    in_valid = 1'b1;
                    in_data  = 8'hEE;
                    @(posedge clk); #1;
                    check("stall_data", out_data, hold_data);
                    check("stall_last", out_last, hold_last);
                    check("stall_in_ready", in_ready, 0);
                end
                in_valid = 1'b0;
            end
            if (rand_bp) begin
                guard = 0;
                do begin
                    r = ($urandom_range(0, 2) != 0);
                    out_ready = r;
                    @(posedge clk); #1;
                    guard++;
                    if (!r) check("bp_hold_data", out_data, exp[k]);
                end while (!r && guard < 16);
                if (!r) begin
                    out_ready = 1'b1;
                    @(posedge clk); #1;
                end
            end else begin
                out_ready = 1'b1;
                @(posedge clk); #1;
            end
            out_ready = 1'b0;
        end
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        $display("frame in=%h expected=%h got=%h", din, exp, got);
    endtask

    vec_t vecs [5];

    task automatic set_vec(input int idx,
                           input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] a2, input logic [7:0] a3,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
        vecs[idx].din = {a3, a2, a1, a0};
`ifdef SORT_DESCENDING_EN
        vecs[idx].exp = {e0, e1, e2, e3};
`else
        vecs[idx].exp = {e3, e2, e1, e0};
`endif
    endtask

    initial begin
        frame_t d;
        // Expected columns are the ascending order; descending build reverses them.
        set_vec(0, 8'h30, 8'h10, 8'h40, 8'h20, 8'h10, 8'h20, 8'h30, 8'h40);
        set_vec(1, 8'hFF, 8'h80, 8'h01, 8'h00, 8'h00, 8'h01, 8'h80, 8'hFF);
        set_vec(2, 8'h05, 8'h05, 8'h00, 8'h05, 8'h00, 8'h05, 8'h05, 8'h05);
        set_vec(3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04);
        set_vec(4, 8'h7A, 8'h7A, 8'h7A, 8'h7A, 8'h7A, 8'h7A, 8'h7A, 8'h7A);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].din, vecs[v].exp, 1'b0, 1'b0);
        end

        // Backpressure on the second output plus ignored in_valid pulses.
        d = {8'h22, 8'h99, 8'h11, 8'h44};
        run_frame(d, ref_sort(d), 1'b1, 1'b0);

        // Reset while phase 2 is pending.
        for (int i = 0; i < DIM; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        d = {8'h01, 8'h02, 8'h03, 8'h04};
        run_frame(d, ref_sort(d), 1'b0, 1'b0);

        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < DIM; i++) begin
                d[i] = (f % 4 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            end
            run_frame(d, ref_sort(d), 1'b0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
